// File: rtl/integration_pkg.sv
// Shared AHB encodings and slave FSM state type for the SRAM slave slice.
package integration_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    RESP_OKAY  = 2'b00,
    RESP_ERROR = 2'b01,
    RESP_RETRY = 2'b10,
    RESP_SPLIT = 2'b11
  } hresp_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } ahb_slv_state_e;

  localparam logic [1:0] HRESP_OKAY  = RESP_OKAY;
  localparam logic [1:0] HRESP_ERROR = RESP_ERROR;

  // Wait-state counter width (WAIT_STATES range 0..7).
  localparam int unsigned WAIT_CNT_W = 3;

endpackage

// File: rtl/ahb_sram_bank.sv
// Word SRAM bank: 2^AW x 32 array, per-byte write enables, synchronous
// write and synchronous registered read on one clock. Read is
// read-before-write when both hit the same word on the same edge.
// Ports: i_clk, i_rst_n (async active-low, read register only),
//        i_we[3:0], i_waddr, i_wdata, i_re, i_raddr, o_rdata.
module ahb_sram_bank #(
  parameter int unsigned AW = 10
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  // Array contents are intentionally not reset.
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_we[b]) begin
        r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  // Read register holds its value between launches.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata <= 32'h0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB SRAM slave: accepts address phases, checks legality, inserts
// WAIT_STATES wait cycles on OKAY transfers, returns the two-cycle ERROR
// response for illegal ones, and commits byte-enabled writes at the end
// of the data phase.
// Ports: hclk, hreset (async active-low), hsel, haddr, htrans, hwrite,
//        hsize, hwdata, hready_in -> hready, hresp, hrdata.
module ahb_sram_slave
  import integration_pkg::*;
#(
  parameter int unsigned MEM_AW      = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hready_in,
  output logic        hready,
  output logic [1:0]  hresp,
  output logic [31:0] hrdata
);

  localparam int unsigned WIN_LSB = MEM_AW + 2;
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_STATES);
  localparam logic ZERO_WAIT = (WAIT_STATES == 0);

  ahb_slv_state_e r_state;
  ahb_slv_state_e w_state_nxt;
  logic [WAIT_CNT_W-1:0] r_cnt;
  logic [WAIT_CNT_W-1:0] w_cnt_nxt;

  logic        r_hready;
  logic [1:0]  r_hresp;
  logic        w_hready_nxt;
  logic [1:0]  w_hresp_nxt;

  logic              w_accept;
  logic              w_aligned;
  logic              w_legal;
  logic [3:0]        w_be;
  logic [MEM_AW-1:0] w_idx;

  logic [MEM_AW-1:0] r_idx;
  logic [3:0]        r_be;
  logic              r_write;
  logic              r_wr_pend;

  logic              w_commit;
  logic              w_rd_acc;
  logic              w_rd_wait;
  logic              w_re;
  logic [MEM_AW-1:0] w_raddr;
  logic [3:0]        w_we;
  logic [31:0]       w_bank_rdata;

  logic [3:0]  r_byp_be;
  logic [31:0] r_byp_data;

  // Address phase decode; only sampled while this slave is ready.
  assign w_accept = hsel && hready_in && r_hready &&
                    ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
  assign w_idx    = haddr[WIN_LSB-1:2];

  always_comb begin
    w_aligned = 1'b0;
    w_be      = 4'b0000;
    case (hsize)
      HSIZE_BYTE: begin
        w_aligned = 1'b1;
        w_be      = 4'b0001 << haddr[1:0];
      end
      HSIZE_HALF: begin
        w_aligned = ~haddr[0];
        w_be      = haddr[1] ? 4'b1100 : 4'b0011;
      end
      HSIZE_WORD: begin
        w_aligned = (haddr[1:0] == 2'b00);
        w_be      = 4'b1111;
      end
      default: begin
        w_aligned = 1'b0;
        w_be      = 4'b0000;
      end
    endcase
  end

  assign w_legal = w_aligned && (haddr[31:WIN_LSB] == BASE_ADDR[31:WIN_LSB]);

  // FSM state register.
  always_ff @(posedge hclk or negedge hreset) begin
    if (!hreset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic; ERR2 and the DONE cycle (IDLE) both take new transfers.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE, ST_ERR2: begin
        w_state_nxt = ST_IDLE;
        if (w_accept) begin
          if (!w_legal) begin
            w_state_nxt = ST_ERR1;
          end else if (!ZERO_WAIT) begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt <= WAIT_CNT_W'(1)) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - WAIT_CNT_W'(1);
        end
      end
      ST_ERR1: w_state_nxt = ST_ERR2;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from the next state so hready/hresp come from flops.
  always_comb begin
    w_hready_nxt = 1'b1;
    w_hresp_nxt  = HRESP_OKAY;
    if ((w_state_nxt == ST_WAIT) || (w_state_nxt == ST_ERR1)) begin
      w_hready_nxt = 1'b0;
    end
    if ((w_state_nxt == ST_ERR1) || (w_state_nxt == ST_ERR2)) begin
      w_hresp_nxt = HRESP_ERROR;
    end
  end

  always_ff @(posedge hclk or negedge hreset) begin
    if (!hreset) begin
      r_hready <= 1'b1;
      r_hresp  <= HRESP_OKAY;
    end else begin
      r_hready <= w_hready_nxt;
      r_hresp  <= w_hresp_nxt;
    end
  end

  assign hready = r_hready;
  assign hresp  = r_hresp;

  // Address-phase capture and pending-write tracking.
  always_ff @(posedge hclk or negedge hreset) begin
    if (!hreset) begin
      r_idx     <= '0;
      r_be      <= 4'b0000;
      r_write   <= 1'b0;
      r_wr_pend <= 1'b0;
    end else begin
      if (w_accept) begin
        r_idx   <= w_idx;
        r_be    <= w_be;
        r_write <= hwrite;
      end
      if (w_accept && w_legal && hwrite) begin
        r_wr_pend <= 1'b1;
      end else if (w_commit) begin
        r_wr_pend <= 1'b0;
      end
    end
  end

  // A pending legal write completes on the edge leaving an IDLE data phase.
  assign w_commit = r_wr_pend && (r_state == ST_IDLE);
  assign w_we     = w_commit ? r_be : 4'b0000;

  // Zero-wait reads launch at acceptance; others on the last wait cycle.
  assign w_rd_acc  = ZERO_WAIT && w_accept && w_legal && !hwrite;
  assign w_rd_wait = (r_state == ST_WAIT) && (r_cnt <= WAIT_CNT_W'(1)) && !r_write;
  assign w_re      = w_rd_acc || w_rd_wait;
  assign w_raddr   = w_rd_acc ? w_idx : r_idx;

  ahb_sram_bank #(
    .AW(MEM_AW)
  ) u_bank (
    .i_clk  (hclk),
    .i_rst_n(hreset),
    .i_we   (w_we),
    .i_waddr(r_idx),
    .i_wdata(hwdata),
    .i_re   (w_re),
    .i_raddr(w_raddr),
    .o_rdata(w_bank_rdata)
  );

  // Bank reads old data on a same-word collision; capture the bytes being written.
  always_ff @(posedge hclk or negedge hreset) begin
    if (!hreset) begin
      r_byp_be   <= 4'b0000;
      r_byp_data <= 32'h0;
    end else if (w_re) begin
      r_byp_be   <= (w_rd_acc && w_commit && (r_idx == w_idx)) ? r_be : 4'b0000;
      r_byp_data <= hwdata;
    end
  end

  always_comb begin
    hrdata = w_bank_rdata;
    for (int b = 0; b < 4; b++) begin
      if (r_byp_be[b]) begin
        hrdata[8*b +: 8] = r_byp_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
module tb_ahb_sram_slave;

  logic        hclk;
  logic        hreset;
  logic        hsel0, hsel1;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        rdy_en;

  logic        hready0, hready1;
  logic        hrdy_in0, hrdy_in1;
  logic [1:0]  hresp0, hresp1;
  logic [31:0] hrdata0, hrdata1;

  int n_pass;
  int n_total;

  assign hrdy_in0 = hready0 & rdy_en;
  assign hrdy_in1 = hready1 & rdy_en;

  ahb_sram_slave #(.MEM_AW(10), .BASE_ADDR(32'h0), .WAIT_STATES(1)) u_dut1 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel1), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready_in(hrdy_in1),
    .hready(hready1), .hresp(hresp1), .hrdata(hrdata1)
  );

  ahb_sram_slave #(.MEM_AW(10), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_dut0 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready_in(hrdy_in0),
    .hready(hready0), .hresp(hresp0), .hrdata(hrdata0)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic bus_idle();
    hsel0 = 1'b0; hsel1 = 1'b0; htrans = 2'b00; hwrite = 1'b0;
    hsize = 3'd2; haddr = 32'h0;
  endtask

  // One non-pipelined transfer; returns observations, called at posedge+1.
  task automatic xfer(input bit use0, input logic [31:0] addr, input logic wr,
                      input logic [2:0] size, input logic [31:0] wdata,
                      output int waits, output logic [31:0] rdata,
                      output logic [1:0] resp_first, output logic [1:0] resp_last);
    hsel0 = use0; hsel1 = !use0; haddr = addr; htrans = 2'b10;
    hwrite = wr; hsize = size;
    @(posedge hclk); #1;
    bus_idle();
    hwdata = wdata;
    resp_first = use0 ? hresp0 : hresp1;
    waits = 0;
    while (((use0 ? hready0 : hready1) !== 1'b1) && (waits < 20)) begin
      waits++;
      @(posedge hclk); #1;
    end
    rdata = use0 ? hrdata0 : hrdata1;
    resp_last = use0 ? hresp0 : hresp1;
    @(posedge hclk); #1;
  endtask

  task automatic test_reset();
    n_total++; if (hready1 !== 1'b1) $display("FAIL reset_hready1: got %b want 1", hready1); else n_pass++;
    n_total++; if (hresp1 !== 2'b00) $display("FAIL reset_hresp1: got %b want 00", hresp1); else n_pass++;
    n_total++; if (hrdata1 !== 32'h0) $display("FAIL reset_hrdata1: got %h want 0", hrdata1); else n_pass++;
    n_total++; if (hready0 !== 1'b1) $display("FAIL reset_hready0: got %b want 1", hready0); else n_pass++;
    n_total++; if (hresp0 !== 2'b00) $display("FAIL reset_hresp0: got %b want 00", hresp0); else n_pass++;
    n_total++; if (hrdata0 !== 32'h0) $display("FAIL reset_hrdata0: got %h want 0", hrdata0); else n_pass++;
  endtask

  task automatic test_wait_rw();
    int w; logic [31:0] rd; logic [1:0] rf, rl;
    xfer(1'b0, 32'h10, 1'b1, 3'd2, 32'hDEAD_BEEF, w, rd, rf, rl);
    n_total++; if (w !== 1) $display("FAIL ws1_write_waits: got %0d want 1", w); else n_pass++;
    n_total++; if (rl !== 2'b00) $display("FAIL ws1_write_resp: got %b want 00", rl); else n_pass++;
    xfer(1'b0, 32'h10, 1'b0, 3'd2, 32'h0, w, rd, rf, rl);
    n_total++; if (w !== 1) $display("FAIL ws1_read_waits: got %0d want 1", w); else n_pass++;
    n_total++; if (rd !== 32'hDEAD_BEEF) $display("FAIL ws1_read_data: got %h want deadbeef", rd); else n_pass++;
    n_total++; if (rf !== 2'b00 || rl !== 2'b00) $display("FAIL ws1_read_resp: got %b/%b want 00/00", rf, rl); else n_pass++;
  endtask

  task automatic test_byte_enables();
    int w; logic [31:0] rd; logic [1:0] rf, rl;
    xfer(1'b0, 32'h10, 1'b1, 3'd2, 32'h1122_3344, w, rd, rf, rl);
    xfer(1'b0, 32'h13, 1'b1, 3'd0, 32'hAA55_6677, w, rd, rf, rl);
    xfer(1'b0, 32'h10, 1'b0, 3'd2, 32'h0, w, rd, rf, rl);
    n_total++; if (rd !== 32'hAA22_3344) $display("FAIL byte_lane3: got %h want aa223344", rd); else n_pass++;
    xfer(1'b0, 32'h12, 1'b1, 3'd1, 32'h9988_7766, w, rd, rf, rl);
    xfer(1'b0, 32'h10, 1'b0, 3'd2, 32'h0, w, rd, rf, rl);
    n_total++; if (rd !== 32'h9988_3344) $display("FAIL half_upper: got %h want 99883344", rd); else n_pass++;
  endtask

  task automatic test_error();
    int w; logic [31:0] rd; logic [1:0] rf, rl;
    xfer(1'b0, 32'h0, 1'b1, 3'd2, 32'hCAFE_F00D, w, rd, rf, rl);
    xfer(1'b0, 32'h1, 1'b1, 3'd1, 32'hFFFF_FFFF, w, rd, rf, rl);
    n_total++; if (rf !== 2'b01) $display("FAIL err1_resp: got %b want 01", rf); else n_pass++;
    n_total++; if (w !== 1) $display("FAIL err_low_cycles: got %0d want 1", w); else n_pass++;
    n_total++; if (rl !== 2'b01) $display("FAIL err2_resp: got %b want 01", rl); else n_pass++;
    xfer(1'b0, 32'h0, 1'b0, 3'd2, 32'h0, w, rd, rf, rl);
    n_total++; if (rd !== 32'hCAFE_F00D) $display("FAIL err_mem_kept: got %h want cafef00d", rd); else n_pass++;
    // ERROR length does not depend on the wait-state setting.
    xfer(1'b1, 32'h2, 1'b0, 3'd2, 32'h0, w, rd, rf, rl);
    n_total++; if (w !== 1 || rf !== 2'b01 || rl !== 2'b01)
      $display("FAIL ws0_err: got waits=%0d resp=%b/%b want 1 01/01", w, rf, rl); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int ok_rdy;
    ok_rdy = 1;
    hsel0 = 1'b1; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h20;
    @(posedge hclk); #1;
    if (hready0 !== 1'b1) ok_rdy = 0;
    hwdata = 32'h5; hwrite = 1'b0; haddr = 32'h20;
    @(posedge hclk); #1;
    if (hready0 !== 1'b1) ok_rdy = 0;
    n_total++; if (hrdata0 !== 32'h5) $display("FAIL bypass_word: got %h want 00000005", hrdata0); else n_pass++;
    hwrite = 1'b1; hsize = 3'd0; haddr = 32'h21;
    @(posedge hclk); #1;
    if (hready0 !== 1'b1) ok_rdy = 0;
    hwdata = 32'h0000_7700; hwrite = 1'b0; hsize = 3'd2; haddr = 32'h20;
    @(posedge hclk); #1;
    if (hready0 !== 1'b1) ok_rdy = 0;
    n_total++; if (hrdata0 !== 32'h0000_7705) $display("FAIL bypass_merge: got %h want 00007705", hrdata0); else n_pass++;
    hwrite = 1'b1; haddr = 32'h24;
    @(posedge hclk); #1;
    if (hready0 !== 1'b1) ok_rdy = 0;
    hwdata = 32'h1234_5678; hwrite = 1'b0; haddr = 32'h20;
    @(posedge hclk); #1;
    if (hready0 !== 1'b1) ok_rdy = 0;
    n_total++; if (hrdata0 !== 32'h0000_7705) $display("FAIL b2b_other_word: got %h want 00007705", hrdata0); else n_pass++;
    haddr = 32'h24;
    @(posedge hclk); #1;
    if (hready0 !== 1'b1) ok_rdy = 0;
    n_total++; if (hrdata0 !== 32'h1234_5678) $display("FAIL b2b_read_after: got %h want 12345678", hrdata0); else n_pass++;
    n_total++; if (hresp0 !== 2'b00) $display("FAIL b2b_resp: got %b want 00", hresp0); else n_pass++;
    n_total++; if (ok_rdy !== 1) $display("FAIL b2b_throughput: got %0d want 1 (hready stayed high)", ok_rdy); else n_pass++;
    bus_idle();
    @(posedge hclk); #1;
  endtask

  task automatic test_illegal_and_idle();
    int w; logic [31:0] rd; logic [1:0] rf, rl;
    xfer(1'b1, 32'h1000, 1'b0, 3'd2, 32'h0, w, rd, rf, rl);
    n_total++; if (rf !== 2'b01 || rl !== 2'b01) $display("FAIL out_of_window: got %b/%b want 01/01", rf, rl); else n_pass++;
    xfer(1'b1, 32'h0, 1'b0, 3'd3, 32'h0, w, rd, rf, rl);
    n_total++; if (rf !== 2'b01 || rl !== 2'b01) $display("FAIL hsize3: got %b/%b want 01/01", rf, rl); else n_pass++;
    xfer(1'b1, 32'hFFC, 1'b1, 3'd2, 32'h0BAD_F00D, w, rd, rf, rl);
    xfer(1'b1, 32'hFFC, 1'b0, 3'd2, 32'h0, w, rd, rf, rl);
    n_total++; if (rd !== 32'h0BAD_F00D || w !== 0 || rl !== 2'b00)
      $display("FAIL top_word: got %h waits=%0d resp=%b want 0badf00d 0 00", rd, w, rl); else n_pass++;
    for (int t = 0; t < 2; t++) begin
      hsel0 = 1'b1; hsel1 = 1'b1; htrans = 2'(t); haddr = 32'h1003; hsize = 3'd3; hwrite = 1'b1;
      @(posedge hclk); #1;
      n_total++; if (hready0 !== 1'b1 || hresp0 !== 2'b00 || hready1 !== 1'b1 || hresp1 !== 2'b00)
        $display("FAIL idle_busy_%0d: got rdy=%b%b resp=%b/%b want 11 00/00", t, hready0, hready1, hresp0, hresp1); else n_pass++;
    end
    bus_idle();
    @(posedge hclk); #1;
  endtask

  task automatic test_hready_in_low();
    int w; logic [31:0] rd; logic [1:0] rf, rl;
    xfer(1'b0, 32'h30, 1'b1, 3'd2, 32'hA5A5_A5A5, w, rd, rf, rl);
    rdy_en = 1'b0;
    hsel1 = 1'b1; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h30;
    @(posedge hclk); #1;
    n_total++; if (hready1 !== 1'b1 || hresp1 !== 2'b00) $display("FAIL hready_in_low: got rdy=%b resp=%b want 1 00", hready1, hresp1); else n_pass++;
    bus_idle();
    hwdata = 32'hFFFF_FFFF;
    @(posedge hclk); #1;
    @(posedge hclk); #1;
    rdy_en = 1'b1;
    xfer(1'b0, 32'h30, 1'b0, 3'd2, 32'h0, w, rd, rf, rl);
    n_total++; if (rd !== 32'hA5A5_A5A5) $display("FAIL hready_in_no_write: got %h want a5a5a5a5", rd); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int w; logic [31:0] rd; logic [1:0] rf, rl;
    xfer(1'b0, 32'h40, 1'b1, 3'd2, 32'h1111_1111, w, rd, rf, rl);
    xfer(1'b0, 32'h40, 1'b0, 3'd2, 32'h0, w, rd, rf, rl);
    hsel1 = 1'b1; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h40;
    @(posedge hclk); #1;
    n_total++; if (hready1 !== 1'b0) $display("FAIL rst_mid_in_wait: got %b want 0", hready1); else n_pass++;
    bus_idle();
    hwdata = 32'h2222_2222;
    hreset = 1'b0;
    #1;
    n_total++; if (hready1 !== 1'b1 || hresp1 !== 2'b00 || hrdata1 !== 32'h0)
      $display("FAIL rst_mid_outputs: got rdy=%b resp=%b data=%h want 1 00 0", hready1, hresp1, hrdata1); else n_pass++;
    @(negedge hclk);
    hreset = 1'b1;
    @(posedge hclk); #1;
    xfer(1'b0, 32'h40, 1'b0, 3'd2, 32'h0, w, rd, rf, rl);
    n_total++; if (rd !== 32'h1111_1111) $display("FAIL rst_mid_discard: got %h want 11111111", rd); else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rdy_en = 1'b1;
    hwdata = 32'h0;
    bus_idle();
    hreset = 1'b0;
    #22;
    hreset = 1'b1;
    @(posedge hclk); #1;
    test_reset();
    test_wait_rw();
    test_byte_enables();
    test_error();
    test_back_to_back();
    test_illegal_and_idle();
    test_hready_in_low();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
